// File: rtl/adder_arb_pkg.sv
// Shared types and default constants for the round-robin shared adder.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } arb_state_t;

    localparam int              DEFAULT_WIDTH = 8;
    localparam int              DEFAULT_BW    = 2;
    localparam logic [7:0]      DEFAULT_BASE  = 8'hAE;

endpackage

// File: rtl/add_core.sv
// Combinational adder: {carry, sum} = A + zero-extended B.
module add_core #(
    parameter int WIDTH = 8,
    parameter int BW    = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [BW-1:0]    b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, a} + {{(WIDTH + 1 - BW){1'b0}}, b};
    assign sum      = full_sum[WIDTH-1:0];
    assign carry    = full_sum[WIDTH];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter serialising two requesters onto one shared adder,
// with registered operands and a valid/ready result stage.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter int               BW    = DEFAULT_BW,
    parameter logic [WIDTH-1:0] BASE  = WIDTH'(DEFAULT_BASE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [BW-1:0]    b0,
    input  logic             use_base0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [BW-1:0]    b1,
    input  logic             use_base1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id
);

    arb_state_t       state_reg, state_next;
    logic             gnt0_reg, gnt1_reg;
    logic             rr_ptr_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [BW-1:0]    op_b_reg;
    logic             id_reg;
    logic             res_valid_reg;
    logic [WIDTH-1:0] res_sum_reg;
    logic             res_carry_reg;
    logic             res_id_reg;

    logic             grant_en;
    logic             winner;
    logic [WIDTH-1:0] core_sum;
    logic             core_carry;

    always_comb begin
        state_next = state_reg;
        grant_en   = 1'b0;
        winner     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    grant_en   = 1'b1;
                    // Contention resolves to the pointer; otherwise the lone requester wins.
                    winner     = (req0 && req1) ? rr_ptr_reg : req1;
                    state_next = CALC;
                end
            end
            CALC:    state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    add_core #(
        .WIDTH (WIDTH),
        .BW    (BW)
    ) u_add_core (
        .a     (op_a_reg),
        .b     (op_b_reg),
        .sum   (core_sum),
        .carry (core_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            gnt0_reg      <= 1'b0;
            gnt1_reg      <= 1'b0;
            rr_ptr_reg    <= 1'b0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            id_reg        <= 1'b0;
            res_valid_reg <= 1'b0;
            res_sum_reg   <= '0;
            res_carry_reg <= 1'b0;
            res_id_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt0_reg  <= grant_en && !winner;
            gnt1_reg  <= grant_en && winner;
            if (grant_en) begin
                op_a_reg   <= winner ? (use_base1 ? BASE : a1) : (use_base0 ? BASE : a0);
                op_b_reg   <= winner ? b1 : b0;
                id_reg     <= winner;
                rr_ptr_reg <= ~winner;
            end
            if (state_reg == CALC) begin
                res_sum_reg   <= core_sum;
                res_carry_reg <= core_carry;
                res_id_reg    <= id_reg;
                res_valid_reg <= 1'b1;
            end
            // Result fields stay put after the handshake; only valid drops.
            if (state_reg == DONE && res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign gnt0      = gnt0_reg;
    assign gnt1      = gnt1_reg;
    assign busy      = (state_reg != IDLE);
    assign res_valid = res_valid_reg;
    assign res_sum   = res_sum_reg;
    assign res_carry = res_carry_reg;
    assign res_id    = res_id_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed-vector bench for adder_arbiter; one line per transaction.
module tb_adder_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, use_base0, use_base1, res_ready;
    logic [7:0] a0, a1;
    logic [1:0] b0, b1;
    logic       gnt0, gnt1, busy, res_valid, res_carry, res_id;
    logic [7:0] res_sum;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    adder_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .use_base0 (use_base0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .use_base1 (use_base1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id)
    );

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests_run++;
        if ({gnt0, gnt1, busy, res_valid, res_carry, res_id} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got gnt0=%b gnt1=%b busy=%b valid=%b carry=%b id=%b, want all 0",
                     gnt0, gnt1, busy, res_valid, res_carry, res_id);
        end
        tests_run++;
        if (res_sum !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_sum: got %h want 00", res_sum);
        end
        $display("[TB] reset: sum=%h valid=%b busy=%b", res_sum, res_valid, busy);
    endtask

    task automatic test_single_ops();
        logic       v_k   [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] v_a   [3] = '{8'h10, 8'h00, 8'hFF};
        logic [1:0] v_b   [3] = '{2'd1, 2'd1, 2'd3};
        logic       v_ub  [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] v_sum [3] = '{8'h11, 8'hAF, 8'h02};
        logic       v_cy  [3] = '{1'b0, 1'b0, 1'b1};
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (v_k[i]) begin
                req1 = 1'b1; a1 = v_a[i]; b1 = v_b[i]; use_base1 = v_ub[i];
            end else begin
                req0 = 1'b1; a0 = v_a[i]; b0 = v_b[i]; use_base0 = v_ub[i];
            end
            tick();
            tests_run++;
            if (gnt0 !== !v_k[i] || gnt1 !== v_k[i] || busy !== 1'b1 || res_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL op%0d_grant: got gnt0=%b gnt1=%b busy=%b valid=%b, want gnt0=%b gnt1=%b busy=1 valid=0",
                         i, gnt0, gnt1, busy, res_valid, !v_k[i], v_k[i]);
            end
            req0 = 1'b0; req1 = 1'b0;
            a0 = 8'h55; a1 = 8'h55; use_base0 = 1'b0; use_base1 = 1'b0;
            tick();
            tests_run++;
            if (res_valid !== 1'b1 || res_sum !== v_sum[i] || res_carry !== v_cy[i] ||
                res_id !== v_k[i] || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL op%0d_result: got valid=%b sum=%h carry=%b id=%b gnt=%b%b, want valid=1 sum=%h carry=%b id=%b gnt=00",
                         i, res_valid, res_sum, res_carry, res_id, gnt0, gnt1, v_sum[i], v_cy[i], v_k[i]);
            end
            tick();
            tests_run++;
            if (res_valid !== 1'b0 || busy !== 1'b0 || res_sum !== v_sum[i]) begin
                tests_failed++;
                $display("FAIL op%0d_accept: got valid=%b busy=%b sum=%h, want valid=0 busy=0 sum=%h",
                         i, res_valid, busy, res_sum, v_sum[i]);
            end
            $display("[TB] op %0d: req%0d sum=%h carry=%b id=%b", i, v_k[i], res_sum, res_carry, res_id);
        end
    endtask

    task automatic test_fairness();
        int grants = 0;
        reset = 1'b1;
        req0 = 1'b1; a0 = 8'h01; b0 = 2'd0; use_base0 = 1'b0;
        req1 = 1'b1; a1 = 8'h02; b1 = 2'd0; use_base1 = 1'b0;
        res_ready = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            logic exp_g0, exp_g1;
            tick();
            exp_g0 = (c % 3 == 1) && (grants % 2 == 0);
            exp_g1 = (c % 3 == 1) && (grants % 2 == 1);
            tests_run++;
            if (gnt0 !== exp_g0 || gnt1 !== exp_g1) begin
                tests_failed++;
                $display("FAIL fair_c%0d: got gnt0=%b gnt1=%b, want gnt0=%b gnt1=%b",
                         c, gnt0, gnt1, exp_g0, exp_g1);
            end
            if (exp_g0 || exp_g1) begin
                $display("[TB] fair cycle %0d: grant %0d to req%0d", c, grants, exp_g1);
                grants++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        req0 = 1'b1; a0 = 8'h05; b0 = 2'd2; use_base0 = 1'b0;
        tick();
        req0 = 1'b0;
        req1 = 1'b1; a1 = 8'h20; b1 = 2'd1; use_base1 = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (res_valid !== 1'b1 || res_sum !== 8'h07 || res_id !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got valid=%b sum=%h id=%b gnt1=%b busy=%b, want valid=1 sum=07 id=0 gnt1=0 busy=1",
                         i, res_valid, res_sum, res_id, gnt1, busy);
            end
        end
        res_ready = 1'b1;
        tick();
        tests_run++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || gnt1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: got valid=%b busy=%b gnt1=%b, want 0 0 0", res_valid, busy, gnt1);
        end
        tick();
        tests_run++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_regrant: got gnt0=%b gnt1=%b, want gnt0=0 gnt1=1", gnt0, gnt1);
        end
        req1 = 1'b0;
        tick();
        tests_run++;
        if (res_valid !== 1'b1 || res_sum !== 8'h21 || res_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_result: got valid=%b sum=%h id=%b, want valid=1 sum=21 id=1", res_valid, res_sum, res_id);
        end
        $display("[TB] backpressure: req1 sum=%h id=%b", res_sum, res_id);
        tick();
    endtask

    task automatic test_reset_midop();
        res_ready = 1'b1;
        req0 = 1'b1; a0 = 8'h40; b0 = 2'd1; use_base0 = 1'b0;
        req1 = 1'b1; a1 = 8'h80; b1 = 2'd2; use_base1 = 1'b0;
        tick();
        tests_run++;
        if (gnt0 !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midop_pregrant: got gnt0=%b busy=%b, want 1 1", gnt0, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || res_sum !== 8'h00) begin
            tests_failed++;
            $display("FAIL midop_calc_reset: got valid=%b busy=%b gnt=%b%b sum=%h, want 0 0 00 00",
                     res_valid, busy, gnt0, gnt1, res_sum);
        end
        tick();
        tests_run++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_calc_regrant: got gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
        end
        res_ready = 1'b0;
        tick();
        tests_run++;
        if (res_valid !== 1'b1 || res_sum !== 8'h41) begin
            tests_failed++;
            $display("FAIL midop_done_result: got valid=%b sum=%h, want 1 41", res_valid, res_sum);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 ||
            res_sum !== 8'h00 || res_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_done_reset: got valid=%b busy=%b gnt=%b%b sum=%h id=%b, want 0 0 00 00 0",
                     res_valid, busy, gnt0, gnt1, res_sum, res_id);
        end
        tick();
        tests_run++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_done_regrant: got gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
        end
        $display("[TB] reset mid-op: regrant gnt0=%b gnt1=%b", gnt0, gnt1);
        req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    // Grants must never coincide, at any point in the run.
    always @(negedge clk) begin
        if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL gnt_exclusive: got gnt0=1 gnt1=1, want at most one");
        end
    end

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; use_base0 = 1'b0; use_base1 = 1'b0;
        a0 = 8'h00; a1 = 8'h00; b0 = 2'd0; b1 = 2'd0; res_ready = 1'b0;
        test_reset();
        test_single_ops();
        test_fairness();
        test_backpressure();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
